// File: rtl/instr_encoder_pkg.sv
// Shared instruction field map and encoder FSM states; the decoder uses the same layout.
package instr_encoder_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam int unsigned OPC_LSB = 28;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned R1_LSB  = 24;
  localparam int unsigned R1_W    = 4;
  localparam int unsigned R2_LSB  = 20;
  localparam int unsigned R2_W    = 4;
  localparam int unsigned RD_LSB  = 16;
  localparam int unsigned RD_W    = 4;
  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned IMM_W   = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush,
    StDone
  } state_e;

  function automatic logic [INSTR_W-1:0] encode(
    input logic [OPC_W-1:0] opc,
    input logic [R1_W-1:0]  r1,
    input logic [R2_W-1:0]  r2,
    input logic [RD_W-1:0]  rd,
    input logic [IMM_W-1:0] imm
  );
    logic [INSTR_W-1:0] w;
    w = '0;
    w[OPC_LSB +: OPC_W] = opc;
    w[R1_LSB +: R1_W]   = r1;
    w[R2_LSB +: R2_W]   = r2;
    w[RD_LSB +: RD_W]   = rd;
    w[IMM_LSB +: IMM_W] = imm;
    return w;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO for encoded words; push while full is accepted only alongside a pop.
module instr_fifo
  import instr_encoder_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = INSTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];

  // Storage is cleared on reset so the head reads zero until the next push.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs instruction fields into 32-bit words and streams them to instruction memory
// from a base address, buffering through a small FIFO.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_opcode,
  input  logic [3:0]         in_reg1,
  input  logic [3:0]         in_reg2,
  input  logic [3:0]         in_dest,
  input  logic [15:0]        in_imm,
  input  logic               in_last,
  output logic               imem_we,
  input  logic               imem_ready,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W:0]    word_count,
  output logic               wrap_err
);

  state_e             state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W:0]    count_q;
  logic               wrap_q;

  logic               fifo_full, fifo_empty;
  logic [INSTR_W-1:0] fifo_head, enc_word;
  logic               in_fire, wr_fire;

  assign in_ready = (state_q == StRun) && !fifo_full;
  assign in_fire  = in_valid && in_ready;
  assign imem_we  = ((state_q == StRun) || (state_q == StFlush)) && !fifo_empty;
  assign wr_fire  = imem_we && imem_ready;
  assign enc_word = encode(in_opcode, in_reg1, in_reg2, in_dest, in_imm);

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_fire),
    .wdata (enc_word),
    .pop   (wr_fire),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      // Writes only happen in RUN/FLUSH, so this never collides with the IDLE load.
      if (wr_fire) begin
        addr_q  <= addr_q + 1'b1;
        count_q <= count_q + 1'b1;
        if (addr_q == '1) wrap_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
            addr_q  <= base_addr;
            count_q <= '0;
            wrap_q  <= 1'b0;
          end
        end
        StRun:   if (in_fire && in_last) state_q <= StFlush;
        StFlush: if (fifo_empty) state_q <= StDone;
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy       = (state_q == StRun) || (state_q == StFlush);
  assign done       = (state_q == StDone);
  assign imem_addr  = addr_q;
  assign imem_wdata = fifo_head;
  assign word_count = count_q;
  assign wrap_err   = wrap_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: table of encodings plus backpressure, wrap,
// ignored-start and mid-load reset sequences.
module tb_instr_encoder;

  localparam int unsigned ADDR_W = 8;

  logic              clk, rst, start, in_valid, in_ready, in_last;
  logic [ADDR_W-1:0] base_addr, imem_addr;
  logic [3:0]        in_opcode, in_reg1, in_reg2, in_dest;
  logic [15:0]       in_imm;
  logic              imem_we, imem_ready, busy, done, wrap_err;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   word_count;

  instr_encoder #(.DEPTH(4), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_reg1    (in_reg1),
    .in_reg2    (in_reg2),
    .in_dest    (in_dest),
    .in_imm     (in_imm),
    .in_last    (in_last),
    .imem_we    (imem_we),
    .imem_ready (imem_ready),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .word_count (word_count),
    .wrap_err   (wrap_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int last_wr_cyc = -1;
  int done_cyc = -1;
  logic [ADDR_W-1:0] wr_addr [$];
  logic [31:0]       wr_data [$];

  // Completed writes are logged mid-cycle; the write lands at the next rising edge.
  always @(negedge clk) begin
    if (!rst && imem_we && imem_ready) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      last_wr_cyc = cyc;
    end
    if (done) done_cyc = cyc;
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [3:0]  opc, r1, r2, rd;
    logic [15:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [31:0] bw(input int i);
    logic [3:0] o, a, d;
    logic [15:0] m;
    o = 4'(i + 1);
    a = 4'(15 - i);
    d = 4'(i);
    m = 16'hA000 + 16'(i);
    return {o, a, 4'h5, d, m};
  endfunction

  task automatic send(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] d, input logic [15:0] m, input logic last);
    int n = 0;
    in_opcode = o; in_reg1 = a; in_reg2 = b; in_dest = d; in_imm = m;
    in_last = last; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_idx(input int i, input logic last);
    send(4'(i + 1), 4'(15 - i), 4'h5, 4'(i), 16'hA000 + 16'(i), last);
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] base);
    start = 1'b1; base_addr = base;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 8'hEE;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    @(negedge clk);
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, done, 1);
    @(negedge clk);
    check({name, "_done_pulse"}, done, 0);
    @(posedge clk); #1;
  endtask

  task automatic check_idle_zero(input string name);
    check({name, "_flags"}, {in_ready, imem_we, busy, done, wrap_err}, 0);
    check({name, "_count"}, word_count, 0);
    check({name, "_addr"}, imem_addr, 0);
    check({name, "_wdata"}, imem_wdata, 0);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'h3, 4'h1, 4'h2, 4'h4, 16'h00FF, 32'h312400FF};
    tbl[1] = '{4'hF, 4'h0, 4'h0, 4'h0, 16'h0000, 32'hF0000000};
    tbl[2] = '{4'h0, 4'hF, 4'h0, 4'h0, 16'h0000, 32'h0F000000};
    tbl[3] = '{4'h0, 4'h0, 4'hF, 4'h0, 16'h0000, 32'h00F00000};
    tbl[4] = '{4'h0, 4'h0, 4'h0, 4'hF, 16'h0000, 32'h000F0000};
    tbl[5] = '{4'h0, 4'h0, 4'h0, 4'h0, 16'hBEEF, 32'h0000BEEF};
    tbl[6] = '{4'hA, 4'h5, 4'hC, 4'h3, 16'h1234, 32'hA5C31234};

    rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    in_opcode = '0; in_reg1 = '0; in_reg2 = '0; in_dest = '0; in_imm = '0;
    imem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_idle_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single encode
    clear_log();
    do_start(8'h10);
    send(4'h3, 4'h1, 4'h2, 4'h4, 16'h00FF, 1'b1);
    wait_done("single");
    check("single_nwrites", wr_addr.size(), 1);
    check("single_addr", wr_addr[0], 8'h10);
    check("single_data", wr_data[0], 32'h312400FF);
    check("single_done_lat", done_cyc - last_wr_cyc, 2);
    check("single_count", word_count, 1);
    check("single_busy", busy, 0);

    // Table of encodings streamed at full rate
    clear_log();
    do_start(8'h40);
    for (int i = 0; i < 7; i++)
      send(tbl[i].opc, tbl[i].r1, tbl[i].r2, tbl[i].rd, tbl[i].imm, i == 6);
    wait_done("table");
    check("table_nwrites", wr_addr.size(), 7);
    for (int i = 0; i < 7 && i < wr_addr.size(); i++) begin
      check($sformatf("table_addr%0d", i), wr_addr[i], 8'h40 + 8'(i));
      check($sformatf("table_data%0d", i), wr_data[i], tbl[i].exp);
    end
    check("table_count", word_count, 7);

    // Backpressure, then full FIFO with simultaneous pop
    clear_log();
    imem_ready = 1'b0;
    do_start(8'h60);
    for (int i = 0; i < 4; i++) send_idx(i, 1'b0);
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_we", imem_we, 1);
    repeat (2) @(negedge clk);
    check("bp_hold_addr", imem_addr, 8'h60);
    check("bp_hold_data", imem_wdata, bw(0));
    check("bp_no_write", wr_addr.size(), 0);
    @(posedge clk); #1;
    imem_ready = 1'b1;
    in_opcode = 4'(5); in_reg1 = 4'(11); in_reg2 = 4'h5; in_dest = 4'(4);
    in_imm = 16'hA004; in_last = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    check("full_in_ready_low", in_ready, 0);
    @(negedge clk);
    check("full_accept_next", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    send_idx(5, 1'b1);
    wait_done("bp");
    check("bp_nwrites", wr_addr.size(), 6);
    for (int i = 0; i < 6 && i < wr_addr.size(); i++) begin
      check($sformatf("bp_addr%0d", i), wr_addr[i], 8'h60 + 8'(i));
      check($sformatf("bp_data%0d", i), wr_data[i], bw(i));
    end
    check("bp_count", word_count, 6);

    // Address wrap
    clear_log();
    do_start(8'hFE);
    send_idx(20, 1'b0);
    send_idx(21, 1'b0);
    send_idx(22, 1'b1);
    wait_done("wrap");
    check("wrap_nwrites", wr_addr.size(), 3);
    if (wr_addr.size() == 3) begin
      check("wrap_addr0", wr_addr[0], 8'hFE);
      check("wrap_addr1", wr_addr[1], 8'hFF);
      check("wrap_addr2", wr_addr[2], 8'h00);
      check("wrap_data2", wr_data[2], bw(22));
    end
    repeat (3) @(posedge clk);
    #1;
    check("wrap_err_hold", wrap_err, 1);
    check("wrap_count_hold", word_count, 3);

    // Start during RUN is ignored
    clear_log();
    do_start(8'h30);
    check("ign_wrap_cleared", wrap_err, 0);
    send_idx(30, 1'b0);
    send_idx(31, 1'b0);
    do_start(8'h80);
    send_idx(32, 1'b0);
    send_idx(33, 1'b1);
    wait_done("ign");
    check("ign_nwrites", wr_addr.size(), 4);
    for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
      check($sformatf("ign_addr%0d", i), wr_addr[i], 8'h30 + 8'(i));
      check($sformatf("ign_data%0d", i), wr_data[i], bw(30 + i));
    end
    check("ign_count", word_count, 4);

    // Reset with words buffered
    clear_log();
    imem_ready = 1'b0;
    do_start(8'h50);
    send_idx(7, 1'b0);
    send_idx(8, 1'b0);
    send_idx(9, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("midrst");
    check("midrst_no_write", wr_addr.size(), 0);
    @(posedge clk); #1;
    imem_ready = 1'b1;
    do_start(8'h20);
    send_idx(10, 1'b0);
    send_idx(11, 1'b1);
    wait_done("midrst");
    check("midrst_nwrites", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check("midrst_addr0", wr_addr[0], 8'h20);
      check("midrst_data0", wr_data[0], bw(10));
      check("midrst_addr1", wr_addr[1], 8'h21);
      check("midrst_data1", wr_data[1], bw(11));
    end
    check("midrst_count", word_count, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
